// File: rtl/jtag_tx_arbiter.sv
// rtl/jtag_tx_arbiter.sv - four-channel round-robin packet arbiter in front of a JTAG byte transmitter
//
// Purpose: picks one of four byte sources round-robin, emits a header byte
// {HDR_TAG, 2'b00, grant}, then forwards that channel's bytes one at a time.
// It waits for the transmitter's acknowledge after every byte. A packet ends
// on req_last or at MAX_LEN payload bytes. A stalled acknowledge aborts the
// packet once TIMEOUT_CYCLES have elapsed.
//
// Ports:
//   CLOCK_50      in   system clock
//   RESET         in   synchronous active-high reset
//   req_valid     in   [3:0]  per-channel byte offered
//   req_data      in   [31:0] per-channel byte, channel n on [8n+7:8n]
//   req_last      in   [3:0]  per-channel end-of-packet flag
//   req_ready     out  [3:0]  one-cycle pulse: channel byte accepted
//   tx_data       out  [7:0]  byte to transmitter, stable until acknowledge
//   tx_load       out         one-cycle pulse: start transfer of tx_data
//   tx_done       in          transmitter completion level (asynchronous)
//   grant         out  [1:0]  channel owning the link while busy
//   busy          out         packet in progress
//   timeout_err   out         sticky acknowledge timeout
//   overflow_err  out         sticky forced termination at MAX_LEN
module jtag_tx_arbiter #(
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter int         MAX_LEN        = 16,
  parameter logic [3:0] HDR_TAG        = 4'hA
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data,
  input  logic [3:0]  req_last,
  output logic [3:0]  req_ready,
  output logic [7:0]  tx_data,
  output logic        tx_load,
  input  logic        tx_done,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        timeout_err,
  output logic        overflow_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = $clog2(MAX_LEN + 1);

  typedef enum logic [2:0] {IDLE, HDR_LOAD, HDR_WAIT, DAT_LOAD, DAT_WAIT} state_t;

  state_t          state;
  logic            sync1, sync2, sync_prev;
  logic            ack;
  logic [1:0]      rr_ptr;
  logic [1:0]      sel;
  logic [TW-1:0]   tmo_cnt;
  logic [CW-1:0]   pay_cnt;
  logic            last_q;
  logic            tmo_hit;

  // Acknowledge is the rising edge of the synchronized completion level.
  assign ack     = sync2 & ~sync_prev;
  // The counter starts at 0 on state entry, so the last permitted cycle sees TIMEOUT_CYCLES-1.
  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Round-robin pick: walk from the farthest offset back to rr_ptr itself so
  // the nearest requesting channel at or after rr_ptr wins.
  always_comb begin
    sel = rr_ptr;
    for (int i = 3; i >= 0; i--) begin
      if (req_valid[rr_ptr + 2'(i)]) sel = rr_ptr + 2'(i);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state        <= IDLE;
      sync1        <= 1'b0;
      sync2        <= 1'b0;
      sync_prev    <= 1'b0;
      rr_ptr       <= 2'd0;
      grant        <= 2'd0;
      busy         <= 1'b0;
      tx_load      <= 1'b0;
      req_ready    <= 4'd0;
      tx_data      <= 8'd0;
      tmo_cnt      <= '0;
      pay_cnt      <= '0;
      last_q       <= 1'b0;
      timeout_err  <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      sync1     <= tx_done;
      sync2     <= sync1;
      sync_prev <= sync2;
      tx_load   <= 1'b0;
      req_ready <= 4'd0;

      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (|req_valid) begin
            grant   <= sel;
            tx_data <= {HDR_TAG, 2'b00, sel};
            tx_load <= 1'b1;
            busy    <= 1'b1;
            state   <= HDR_LOAD;
          end
        end

        HDR_LOAD: begin
          tmo_cnt <= '0;
          state   <= HDR_WAIT;
        end

        HDR_WAIT: begin
          if (ack) begin
            pay_cnt <= '0;
            tmo_cnt <= '0;
            state   <= DAT_LOAD;
          end else if (tmo_hit) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            rr_ptr      <= grant + 2'd1;
            tmo_cnt     <= '0;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        DAT_LOAD: begin
          if (req_valid[grant]) begin
            tx_data   <= req_data[{grant, 3'b000} +: 8];
            last_q    <= req_last[grant];
            tx_load   <= 1'b1;
            req_ready <= 4'b0001 << grant;
            pay_cnt   <= pay_cnt + 1'b1;
            tmo_cnt   <= '0;
            state     <= DAT_WAIT;
          end else if (tmo_hit) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            rr_ptr      <= grant + 2'd1;
            tmo_cnt     <= '0;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        DAT_WAIT: begin
          if (ack) begin
            tmo_cnt <= '0;
            if (last_q || pay_cnt == CW'(MAX_LEN)) begin
              // Without req_last this is a forced cut; the channel's
              // remaining bytes re-arbitrate as a fresh packet.
              if (!last_q) overflow_err <= 1'b1;
              busy   <= 1'b0;
              rr_ptr <= grant + 2'd1;
              state  <= IDLE;
            end else begin
              state <= DAT_LOAD;
            end
          end else if (tmo_hit) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            rr_ptr      <= grant + 2'd1;
            tmo_cnt     <= '0;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_tx_arbiter.sv
// tb/tb_jtag_tx_arbiter.sv - scoreboard bench for jtag_tx_arbiter
module tb_jtag_tx_arbiter;

  localparam int TMO = 100;

  logic        CLOCK_50 = 1'b0;
  logic        RESET = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_load;
  logic        tx_done = 1'b0;
  logic [1:0]  grant;
  logic        busy;
  logic        timeout_err;
  logic        overflow_err;

  int checks = 0;
  int errors = 0;

  logic [8:0] src_q [4][$];   // {last, data} per channel
  logic [9:0] exp_q [$];      // {grant, byte} expected at each tx_load
  int         rdy_cnt [4] = '{0, 0, 0, 0};
  int         load_cnt = 0;
  bit         ack_en = 1'b1;
  int         ack_dly = 5;

  jtag_tx_arbiter #(.TIMEOUT_CYCLES(TMO), .MAX_LEN(16), .HDR_TAG(4'hA)) dut (
    .CLOCK_50(CLOCK_50), .RESET(RESET), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data), .tx_load(tx_load),
    .tx_done(tx_done), .grant(grant), .busy(busy), .timeout_err(timeout_err),
    .overflow_err(overflow_err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Channel sources: present the queue head, advance on a ready pulse.
  always @(negedge CLOCK_50) begin
    for (int ch = 0; ch < 4; ch++) begin
      if (req_ready[ch] && src_q[ch].size() > 0) void'(src_q[ch].pop_front());
      if (src_q[ch].size() > 0) begin
        req_valid[ch]          = 1'b1;
        req_last[ch]           = src_q[ch][0][8];
        req_data[ch*8 +: 8]    = src_q[ch][0][7:0];
      end else begin
        req_valid[ch]          = 1'b0;
        req_last[ch]           = 1'b0;
      end
    end
  end

  // Transmitter model: completion level rises ack_dly cycles after a load, high for 2 cycles.
  always begin
    @(negedge CLOCK_50);
    if (tx_load && ack_en) begin
      repeat (ack_dly) @(negedge CLOCK_50);
      tx_done = 1'b1;
      repeat (2) @(negedge CLOCK_50);
      tx_done = 1'b0;
    end
  end

  // Output monitor and scoreboard compare.
  always @(negedge CLOCK_50) begin
    logic [9:0] e;
    if (tx_load) begin
      load_cnt++;
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("tx_data", 32'(tx_data), 32'(e[7:0]));
        check("tx_grant", 32'(grant), 32'(e[9:8]));
      end
    end
    if (req_ready != 4'd0) begin
      for (int ch = 0; ch < 4; ch++) if (req_ready[ch]) rdy_cnt[ch]++;
      check("ready_onehot", 32'(req_ready), 32'(4'b0001 << grant));
      check("ready_with_load", 32'(tx_load), 32'd1);
    end
  end

  task automatic drain(input string tag, input int bound);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < bound) begin
      @(negedge CLOCK_50);
      n++;
    end
    check(tag, 32'(n < bound), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    RESET = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    RESET = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_load"}, 32'(tx_load), 32'd0);
    check({tag, "_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_data"}, 32'(tx_data), 32'd0);
    check({tag, "_grant"}, 32'(grant), 32'd0);
    check({tag, "_terr"}, 32'(timeout_err), 32'd0);
    check({tag, "_oerr"}, 32'(overflow_err), 32'd0);
  endtask

  initial begin
    int r0, l0, n;
    bit seen;

    // Reset values.
    repeat (3) @(negedge CLOCK_50);
    RESET = 1'b0;
    check_reset_vals("rst");

    // Ch0 and ch3 together from reset: ch0, ch3, then ch0's second packet.
    do_reset();
    ack_dly = 3;
    src_q[0].push_back({1'b1, 8'h10});
    src_q[0].push_back({1'b1, 8'h11});
    src_q[3].push_back({1'b0, 8'h30});
    src_q[3].push_back({1'b1, 8'h31});
    exp_q.push_back({2'd0, 8'hA0}); exp_q.push_back({2'd0, 8'h10});
    exp_q.push_back({2'd3, 8'hA3}); exp_q.push_back({2'd3, 8'h30}); exp_q.push_back({2'd3, 8'h31});
    exp_q.push_back({2'd0, 8'hA0}); exp_q.push_back({2'd0, 8'h11});
    drain("rr_drain", 2000);

    // Single byte on ch2 with 5-cycle acknowledge.
    do_reset();
    ack_dly = 5;
    r0 = rdy_cnt[2];
    l0 = load_cnt;
    src_q[2].push_back({1'b1, 8'h3C});
    exp_q.push_back({2'd2, 8'hA2}); exp_q.push_back({2'd2, 8'h3C});
    drain("ch2_drain", 500);
    check("ch2_ready_pulses", 32'(rdy_cnt[2] - r0), 32'd1);
    check("ch2_loads", 32'(load_cnt - l0), 32'd2);
    check("ch2_oerr", 32'(overflow_err), 32'd0);

    // Ch1 streams 20 bytes without last: cut at 16, new header, then stall to timeout.
    ack_dly = 1;
    exp_q.push_back({2'd1, 8'hA1});
    for (int i = 0; i < 20; i++) begin
      src_q[1].push_back({1'b0, 8'(8'h40 + i)});
      if (i == 16) exp_q.push_back({2'd1, 8'hA1});
      exp_q.push_back({2'd1, 8'(8'h40 + i)});
    end
    drain("ovf_drain", 3000);
    check("ovf_oerr", 32'(overflow_err), 32'd1);
    check("ovf_tail_terr", 32'(timeout_err), 32'd1);

    // Header never acknowledged: timeout after TMO cycles of waiting.
    do_reset();
    check("tmo_pre_terr", 32'(timeout_err), 32'd0);
    ack_en = 1'b0;
    src_q[0].push_back({1'b1, 8'h77});
    exp_q.push_back({2'd0, 8'hA0});
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge CLOCK_50);
      n++;
      if (tx_load) seen = 1'b1;
    end
    check("tmo_hdr_seen", 32'(seen), 32'd1);
    src_q[0].delete();
    n = 0;
    while (!timeout_err && n < 1000) begin
      @(negedge CLOCK_50);
      if (!timeout_err) n++;
    end
    check("tmo_cycles", 32'(n), 32'(TMO));
    check("tmo_terr", 32'(timeout_err), 32'd1);
    check("tmo_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge CLOCK_50);
    check("tmo_idle_busy", 32'(busy), 32'd0);

    // Reset pulse during DAT_WAIT; the late completion edge must not load.
    do_reset();
    ack_en = 1'b1;
    ack_dly = 8;
    src_q[3].push_back({1'b1, 8'h55});
    exp_q.push_back({2'd3, 8'hA3}); exp_q.push_back({2'd3, 8'h55});
    n = 0;
    seen = 1'b0;
    while (!seen && n < 300) begin
      @(negedge CLOCK_50);
      n++;
      if (req_ready[3]) seen = 1'b1;
    end
    check("rstmid_ready_seen", 32'(seen), 32'd1);
    RESET = 1'b1;
    @(negedge CLOCK_50);
    RESET = 1'b0;
    check_reset_vals("rstmid");
    l0 = load_cnt;
    repeat (30) @(negedge CLOCK_50);
    check("rstmid_no_load", 32'(load_cnt - l0), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global time limit");
  end

endmodule
